// File: rtl/avalon_arb_pkg.sv
// avalon_arb_pkg: shared types and round-robin pick for the two-master Avalon arbiter
package avalon_arb_pkg;
  localparam int NBMASTERS = 2;
  typedef logic master_id_t;
  typedef struct packed {
    logic       valid;
    master_id_t id;
  } pick_t;
  function automatic pick_t rr_pick(input logic [NBMASTERS-1:0] elig, input master_id_t last);
    return '{valid: |elig, id: &elig ? ~last : elig[1]};
  endfunction
endpackage

// File: rtl/avalon_pipeline_arbiter_if.sv
// avalon_pipeline_arbiter_if: pipelined Avalon-MM bus with master/slave views
interface avalon_pipeline_arbiter_if #(parameter int NBADDRBITS = 8, parameter int NBDATABYTES = 2);
  logic [NBADDRBITS-1:0]    address;
  logic [NBDATABYTES-1:0]   byteenable;
  logic [8*NBDATABYTES-1:0] writedata;
  logic [8*NBDATABYTES-1:0] readdata;
  logic                     read;
  logic                     write;
  logic                     waitrequest;
  logic                     readdatavalid;
  modport master (output address, byteenable, writedata, read, write,
                  input waitrequest, readdata, readdatavalid);
  modport slave (input address, byteenable, writedata, read, write,
                 output waitrequest, readdata, readdatavalid);
endinterface

// File: rtl/avalon_id_fifo.sv
// avalon_id_fifo: small FIFO of master IDs for outstanding reads
module avalon_id_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 1,
  localparam int CW = $clog2(DEPTH + 1),
  localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             empty,
  output logic             full,
  output logic [CW-1:0]    count
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0] wp, rp;
  logic wr, rd;
  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return p == PW'(DEPTH - 1) ? '0 : p + 1'b1;
  endfunction
  assign wr = push & !full;
  assign rd = pop & !empty;
  assign empty = count == '0;
  assign full = count == CW'(DEPTH);
  assign head = mem[rp];
  always_ff @(posedge clk) if (wr) mem[wp] <= push_data;
  always_ff @(posedge clk) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      if (wr) wp <= nxt(wp);
      if (rd) rp <= nxt(rp);
      count <= count + CW'(wr) - CW'(rd);
    end
  end
endmodule

// File: rtl/avalon_pipeline_arbiter.sv
// avalon_pipeline_arbiter: round-robin share of one pipelined Avalon-MM slave between two masters
module avalon_pipeline_arbiter
  import avalon_arb_pkg::*;
#(
  parameter int NBADDRBITS = 8,
  parameter int NBDATABYTES = 2,
  parameter int MAXPENDING = 4,
  localparam int CW = $clog2(MAXPENDING + 1)
) (
  input  logic                         clk,
  input  logic                         rst,
  avalon_pipeline_arbiter_if.slave     m0,
  avalon_pipeline_arbiter_if.slave     m1,
  avalon_pipeline_arbiter_if.master    s,
  output logic [CW-1:0]                pending_count,
  output logic                         err_unexpected_rdv
);
  logic [NBMASTERS-1:0] elig;
  logic [NBADDRBITS-1:0] addr;
  logic [NBDATABYTES-1:0] be;
  logic [8*NBDATABYTES-1:0] wdata;
  logic locked, gv, rd, wr, acc, pop, empty, full, rd_ok;
  master_id_t lock_id, last_grant, grant, head;
  pick_t pk;
  assign rd_ok = pending_count < CW'(MAXPENDING);
  assign elig = {m1.write | (m1.read & rd_ok), m0.write | (m0.read & rd_ok)};
  assign pk = rr_pick(elig, last_grant);
  assign grant = locked ? lock_id : pk.id;
  assign gv = !rst & (locked | pk.valid);
  assign addr = grant ? m1.address : m0.address;
  assign be = grant ? m1.byteenable : m0.byteenable;
  assign wdata = grant ? m1.writedata : m0.writedata;
  assign wr = grant ? m1.write : m0.write;
  assign rd = grant ? m1.read : m0.read;
  assign s.address = addr;
  assign s.byteenable = be;
  assign s.writedata = wdata;
  // a simultaneous read+write is a write, so the read never reaches the slave
  assign s.write = gv & wr;
  assign s.read = gv & rd & !wr;
  assign acc = (s.read | s.write) & !s.waitrequest;
  assign m0.waitrequest = !(gv & !grant) | s.waitrequest;
  assign m1.waitrequest = !(gv & grant) | s.waitrequest;
  assign m0.readdata = s.readdata;
  assign m1.readdata = s.readdata;
  assign pop = !rst & s.readdatavalid & !empty;
  assign m0.readdatavalid = pop & !head;
  assign m1.readdatavalid = pop & head;
  avalon_id_fifo #(.DEPTH(MAXPENDING), .WIDTH(1)) u_fifo (
    .clk, .rst, .push(acc & s.read), .push_data(grant), .pop,
    .head, .empty, .full, .count(pending_count)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      locked <= 1'b0;
      lock_id <= 1'b0;
      last_grant <= 1'b1;
      err_unexpected_rdv <= 1'b0;
    end else begin
      locked <= (s.read | s.write) & s.waitrequest;
      lock_id <= grant;
      if (acc) last_grant <= grant;
      if (s.readdatavalid & empty) err_unexpected_rdv <= 1'b1;
    end
  end
endmodule

// File: tb/tb_avalon_pipeline_arbiter.sv
// tb_avalon_pipeline_arbiter: directed scoreboard bench for the two-master arbiter
module tb_avalon_pipeline_arbiter;
  typedef struct packed {
    logic        id;
    logic [15:0] d;
  } exp_t;
  logic clk = 0, rst = 1;
  logic [2:0] pc;
  logic err;
  int n_cmp = 0, n_err = 0;
  exp_t q[$];
  always #5 clk = ~clk;
  avalon_pipeline_arbiter_if #(.NBADDRBITS(8), .NBDATABYTES(2)) m0(), m1(), s();
  avalon_pipeline_arbiter #(.NBADDRBITS(8), .NBDATABYTES(2), .MAXPENDING(4)) dut (
    .clk(clk), .rst(rst), .m0(m0), .m1(m1), .s(s),
    .pending_count(pc), .err_unexpected_rdv(err)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic look;
    @(negedge clk);
  endtask
  task automatic rsp(input logic id, input logic [15:0] d);
    q.push_back('{id, d});
    s.readdatavalid = 1;
    s.readdata = d;
    tick();
    s.readdatavalid = 0;
  endtask
  always @(negedge clk) begin
    exp_t e;
    if (m0.readdatavalid || m1.readdatavalid) begin
      if (q.size() == 0) chk("spurious_rdv", {m1.readdatavalid, m0.readdatavalid}, 0);
      else begin
        e = q.pop_front();
        chk("rdv_route", {m1.readdatavalid, m0.readdatavalid}, e.id ? 2'b10 : 2'b01);
        chk("rdv_data0", m0.readdata, e.d);
        chk("rdv_data1", m1.readdata, e.d);
      end
    end
  end
  initial begin
    m0.address = 0; m0.byteenable = 2'b11; m0.writedata = 0; m0.read = 0; m0.write = 0;
    m1.address = 0; m1.byteenable = 2'b11; m1.writedata = 0; m1.read = 0; m1.write = 0;
    s.waitrequest = 0; s.readdata = 0; s.readdatavalid = 0;
    m0.read = 1; s.readdatavalid = 1;
    tick(); look();
    chk("rst_sread", s.read, 0);
    chk("rst_m0wait", m0.waitrequest, 1);
    chk("rst_m1wait", m1.waitrequest, 1);
    chk("rst_rdv", {m1.readdatavalid, m0.readdatavalid}, 0);
    tick();
    rst = 0; m0.read = 0; s.readdatavalid = 0;
    look();
    chk("rst_pc", pc, 0);
    chk("rst_err", err, 0);
    tick();
    m0.address = 8'h10; m0.read = 1;
    look();
    chk("t1_sread", s.read, 1);
    chk("t1_addr", s.address, 8'h10);
    chk("t1_m0wait", m0.waitrequest, 0);
    chk("t1_m1wait", m1.waitrequest, 1);
    tick();
    m0.read = 0;
    look(); chk("t1_pc1", pc, 1);
    tick();
    rsp(0, 16'hBEEF);
    look(); chk("t1_pc0", pc, 0);
    tick();
    rst = 1; tick(); rst = 0;
    m0.address = 8'h20; m1.address = 8'h30; m0.read = 1; m1.read = 1;
    for (int i = 0; i < 4; i++) begin
      look(); chk("t2_alt_addr", s.address, i % 2 ? 8'h30 : 8'h20);
      tick();
    end
    look();
    chk("t2_full_sread", s.read, 0);
    chk("t2_pc4", pc, 4);
    tick();
    m0.read = 0; m1.read = 0;
    rsp(0, 16'h1111); rsp(1, 16'h2222); rsp(0, 16'h3333); rsp(1, 16'h4444);
    look(); chk("t2_pc0", pc, 0);
    tick();
    m0.address = 8'h40; m1.address = 8'h50; m0.read = 1; m1.read = 1; s.waitrequest = 1;
    for (int i = 0; i < 3; i++) begin
      look();
      chk("t3_wait_addr", s.address, 8'h40);
      chk("t3_wait_m0", m0.waitrequest, 1);
      chk("t3_wait_m1", m1.waitrequest, 1);
      tick();
    end
    s.waitrequest = 0;
    look();
    chk("t3_acc_addr", s.address, 8'h40);
    chk("t3_acc_m0", m0.waitrequest, 0);
    tick();
    m0.read = 0;
    look();
    chk("t3_m1_addr", s.address, 8'h50);
    chk("t3_m1_wait", m1.waitrequest, 0);
    tick();
    m1.read = 0;
    rsp(0, 16'h4040); rsp(1, 16'h5050);
    m1.address = 8'h60; m1.read = 1; s.waitrequest = 1;
    look(); chk("t3b_addr0", s.address, 8'h60);
    tick();
    m0.address = 8'h70; m0.read = 1;
    look();
    chk("t3b_lock_addr", s.address, 8'h60);
    chk("t3b_lock_m0wait", m0.waitrequest, 1);
    tick();
    s.waitrequest = 0;
    look();
    chk("t3b_acc_addr", s.address, 8'h60);
    chk("t3b_acc_m1wait", m1.waitrequest, 0);
    tick();
    m1.read = 0;
    look(); chk("t3b_m0_addr", s.address, 8'h70);
    tick();
    m0.read = 0;
    rsp(1, 16'h6060); rsp(0, 16'h7070);
    m0.address = 8'h80; m0.read = 1;
    for (int i = 0; i < 4; i++) begin
      look(); chk("t4_fill_sread", s.read, 1);
      tick();
    end
    m1.address = 8'h90; m1.writedata = 16'hABCD; m1.write = 1;
    look();
    chk("t4_full_sread", s.read, 0);
    chk("t4_full_m0wait", m0.waitrequest, 1);
    chk("t4_swrite", s.write, 1);
    chk("t4_waddr", s.address, 8'h90);
    chk("t4_wdata", s.writedata, 16'hABCD);
    chk("t4_m1wait", m1.waitrequest, 0);
    chk("t4_pc4", pc, 4);
    tick();
    m1.write = 0;
    look();
    chk("t4_pc4_after_wr", pc, 4);
    chk("t4_still_blocked", s.read, 0);
    tick();
    q.push_back('{1'b0, 16'h8181});
    s.readdatavalid = 1; s.readdata = 16'h8181;
    look(); chk("t4_no_bypass", s.read, 0);
    tick();
    s.readdatavalid = 0;
    look();
    chk("t4_pc3", pc, 3);
    chk("t4_resume_sread", s.read, 1);
    chk("t4_resume_m0wait", m0.waitrequest, 0);
    tick();
    m0.read = 0;
    look(); chk("t4_pc_refill", pc, 4);
    tick();
    rsp(0, 16'h8282); rsp(0, 16'h8383); rsp(0, 16'h8484); rsp(0, 16'h8585);
    m0.read = 1; m0.write = 1;
    look();
    chk("rw_swrite", s.write, 1);
    chk("rw_sread", s.read, 0);
    tick();
    m0.read = 0; m0.write = 0;
    look(); chk("rw_no_push", pc, 0);
    tick();
    rst = 1; tick(); rst = 0;
    look(); chk("t5_err0", err, 0);
    tick();
    s.readdatavalid = 1;
    look(); chk("t5_no_valid", {m1.readdatavalid, m0.readdatavalid}, 0);
    tick();
    s.readdatavalid = 0;
    look(); chk("t5_err1", err, 1);
    tick(); tick();
    look(); chk("t5_err_sticky", err, 1);
    tick();
    rst = 1; tick(); rst = 0;
    look(); chk("t5_err_clr", err, 0);
    tick();
    m0.address = 8'h20; m1.address = 8'h30; m0.read = 1; m1.read = 1;
    tick(); tick();
    m0.read = 0; m1.read = 0;
    look(); chk("t6_pc2", pc, 2);
    tick();
    rst = 1; tick(); rst = 0;
    look();
    chk("t6_pc0", pc, 0);
    chk("t6_err0", err, 0);
    tick();
    s.readdatavalid = 1; tick(); s.readdatavalid = 0;
    look(); chk("t6_late_err", err, 1);
    tick();
    m0.read = 1; m1.read = 1;
    look(); chk("t6_m0_wins", s.address, 8'h20);
    tick();
    m0.read = 0; m1.read = 0;
    tick();
    chk("q_empty", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/avalon_pipeline_arbiter.md
Name: avalon_pipeline_arbiter

Overview:
- Shares one pipelined, variable-latency Avalon-MM slave between two Avalon-MM masters (m0, m1).
- Arbitration is round-robin. The command path is combinational, so it adds no latency.
- A small ID FIFO records which master issued each accepted read. Each readdatavalid beat is routed back to that master.
- Sits between the bench/BFM masters and the DUT slave that the Avalon protocol assertion checker observes.

Parameters:
- NBADDRBITS, 8, address width.
- NBDATABYTES, 2, data bytes per word. Data width is 8*NBDATABYTES; byteenable width is NBDATABYTES.
- MAXPENDING, 4, maximum outstanding reads. Range 1..16.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous reset, active-high.
- m0_address / m1_address  in  NBADDRBITS  master address.
- m0_byteenable / m1_byteenable  in  NBDATABYTES  master byte enables.
- m0_writedata / m1_writedata  in  8*NBDATABYTES  master write data.
- m0_read / m1_read, m0_write / m1_write  in  1  master commands.
- m0_waitrequest / m1_waitrequest  out  1  stall to master.
- m0_readdata / m1_readdata  out  8*NBDATABYTES  s_readdata broadcast to both masters.
- m0_readdatavalid / m1_readdatavalid  out  1  routed read-response valid.
- s_address, s_byteenable, s_writedata, s_read, s_write  out  widths as above  slave command.
- s_waitrequest  in  1  slave stall.
- s_readdata  in  8*NBDATABYTES  slave read data.
- s_readdatavalid  in  1  slave response valid.
- pending_count  out  $clog2(MAXPENDING+1)  registered number of outstanding reads.
- err_unexpected_rdv  out  1  sticky: readdatavalid received with no outstanding read.

Behaviour:
- Request: master i requests when mi_read | mi_write.
  - A read request is eligible only if pending_count < MAXPENDING.
  - The count is registered, so there is no bypass from a same-cycle pop.
  - Write requests are always eligible.
- Grant selection (combinational):
  - If locked, grant = lock_id.
  - Else if exactly one master is eligible, grant that master.
  - Else if both are eligible, grant the master != last_grant.
  - Else there is no grant.
- Slave side:
  - Granted master's command fields are muxed to s_*.
  - With no grant, s_read = s_write = 0; address/data are don't-care and are driven with m0's values.
- Master stall: mi_waitrequest = 1 unless i is granted, in which case mi_waitrequest = s_waitrequest.
  - An idle master also sees waitrequest = 1.
- Lock:
  - Set when a command is presented (s_read | s_write) with s_waitrequest = 1.
  - lock_id = current grant. Cleared on the cycle the command is accepted.
  - This keeps the slave command stable during a wait, as Avalon requires.
- Accept: s_read | s_write with !s_waitrequest.
  - On accept, last_grant <= grant.
  - On a read accept, push grant id into the FIFO.
- Response:
  - On s_readdatavalid with the FIFO non-empty, pop the head. Set m<head>_readdatavalid = 1 in the same cycle (0-cycle routing); the other master's valid = 0.
  - On s_readdatavalid with the FIFO empty: no pop, both valids = 0, err_unexpected_rdv <= 1.
- Push and pop in the same cycle: pending_count unchanged, FIFO order preserved.
  - This is legal even when count = MAXPENDING, because a push at count = MAXPENDING cannot occur.
- Pointers: wrap modulo MAXPENDING. pending_count never exceeds MAXPENDING.
- Master asserts read & write together: treated as a write. Read is ignored, no push.
- Reset:
  - last_grant = 1 (so m0 wins the first contention), lock cleared, FIFO empty, pending_count = 0, err_unexpected_rdv = 0.
  - While rst = 1: s_read = s_write = 0, m0/m1_waitrequest = 1, m0/m1_readdatavalid = 0.
  - Reset mid-transaction drops all outstanding IDs; late slave responses after reset set err_unexpected_rdv.

Decomposition:
- Package avalon_arb_pkg: typedef master_id_t (1 bit), constant NBMASTERS = 2, function for the round-robin pick.
- Sub-module avalon_id_fifo:
  - Parameters DEPTH, WIDTH.
  - Ports: push, push_data, pop, head, empty, full, count.
  - Synchronous reset on clk/rst.

Test Plan:
- Single master: m0 reads addr 0x10, slave returns 0xBEEF two cycles later → m0_readdatavalid = 1 with readdata 0xBEEF, m1_readdatavalid = 0, pending_count 1 → 0.
- Contention: m0 and m1 both read continuously from reset → accepts alternate m0, m1, m0, m1. Responses return in order to m0, m1, m0, m1.
- Wait lock: both request, m0 granted, s_waitrequest = 1 for 3 cycles while m1 still requests → s_address holds m0's value for all 4 cycles. m1 is granted the cycle after m0's accept.
- Full FIFO (MAXPENDING = 4): 4 reads accepted with no responses → 5th read is not presented (s_read = 0, m0_waitrequest = 1), while an m1 write is accepted. After 1 response, the read is accepted the next cycle.
- Unexpected response: s_readdatavalid pulse after reset with no read issued → no master valid, err_unexpected_rdv = 1 until rst.
- Reset mid-operation: rst with 2 reads pending → pending_count = 0, err_unexpected_rdv = 0, first contention after reset won by m0.
